systolic_feeder_4x4: RTL
========================

# systolic_feeder_4x4

Operand sequencer for the 4x4 output-stationary systolic array. It latches two 4x4 signed int8 matrices A and B on a start request, then clears the array accumulators. It streams the matrices into the array's a1..a4 / b1..b4 edges in skewed (diagonal-wavefront) order, waits for the wavefront to drain, and pulses done when c11..c44 hold A×B. It is the transmitting end of the array's edge-operand protocol and replaces hand-sequenced stimulus.

## Interface
Parameters:
- DATA_W, 8, operand width (signed two's complement).
- DRAIN_CYCLES, 10, cycles waited after the last operand before done; must be ≥ 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a_mat  in  16*DATA_W  A[r][c] at bits [(r*4+c)*DATA_W +: DATA_W], r,c in 0..3.
- b_mat  in  16*DATA_W  B[r][c], same packing.
- arr_clr  out  1  accumulator clear to the array (drives the array's rst).
- a1..a4  out  DATA_W each, signed  row operands; a(i+1) feeds array row i.
- b1..b4  out  DATA_W each, signed  column operands; b(j+1) feeds array column j.
- busy  out  1  high from CLEAR through the DONE cycle.
- done  out  1  one-cycle pulse; results valid at the array outputs.

## Operation
- FSM states: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- IDLE: outputs zero. start=1 latches a_mat/b_mat into internal registers and moves to CLEAR.
- CLEAR: one cycle with arr_clr=1 and operands zero, then FEED.
- FEED: 7 cycles with step counter k=0..6.
  - a(i+1) = A[i][k-i] when 0 ≤ k-i ≤ 3, else 0.
  - b(j+1) = B[k-j][j] when 0 ≤ k-j ≤ 3, else 0.
  - After k=6, go to DRAIN.
- DRAIN: operands zero for DRAIN_CYCLES cycles (counter), then DONE.
- DONE: done=1 for one cycle, busy=1; then IDLE.
- start outside IDLE is ignored. a_mat/b_mat changes after the latch have no effect on the run.
- No arithmetic in the block. Operands pass bit-exact, including -128.

## Timing
- All outputs are registered. Reset value of every output is 0: arr_clr, a1..a4, b1..b4, busy, done. Internal state resets to IDLE with counters at 0.
- Cycle 0 = the edge that samples start=1 in IDLE.
- Cycle 1: arr_clr=1, busy=1.
- Cycles 2..8: FEED, k = cycle-2.
- Cycles 9..8+DRAIN_CYCLES: DRAIN.
- Cycle 9+DRAIN_CYCLES: done=1.
- Cycle 10+DRAIN_CYCLES: IDLE, busy=0. start may be sampled on this same edge, so back-to-back runs are spaced 10+DRAIN_CYCLES cycles apart.
- start held high through a run begins exactly one further run, at the first IDLE cycle.
- rst=1 at any point, including mid-FEED, forces IDLE and zero outputs on the next edge. No done is produced for the aborted run. Latched matrices may be retained but are never emitted without a new start.
- rst and start together: rst wins.

## Structure
- Shared package `systolic_pkg`:
  - N=4.
  - DATA_W default.
  - feeder state enum {IDLE, CLEAR, FEED, DRAIN, DONE}.
  - Helper function for the flat-matrix index (r*N+c)*DATA_W.
- One natural sub-module, `systolic_skew_lane`:
  - Per-lane selector: given the lane index, k, and the 4 latched lane elements, registers the element or 0.
  - Instantiated 8 times: 4 rows of A, 4 columns of B.
- Top contains the FSM, the k and drain counters, and the matrix latch.

## Test plan
- Reference run: A[r][c]=r+c+1, B[r][c]=r+c+5, feeder wired to the 4x4 array, start at cycle 0 → done at cycle 19. c11..c44 = 70 80 90 100 / 96 110 124 138 / 122 140 158 176 / 148 170 192 214.
- Stream check, same matrices:
  - a1 = 1,2,3,4,0,0,0 over k=0..6.
  - a4 = 0,0,0,4,5,6,7.
  - b2 = 0,6,7,8,9,0,0.
  - arr_clr high only at cycle 1.
- Extremes: A = all -128, B = all 127 → every c = 4·(-128·127) = -65024. Operands observed exactly as 0x80/0x7F.
- Start while busy: pulse start at cycles 3 and 15, change a_mat at cycle 4 → a single done at 19, results from the original matrices.
- Reset mid-FEED: rst=1 at cycle 5 → cycle 6 has all outputs 0 and busy=0, and no done. A new start then yields correct results with done 19 cycles after start.
- Back-to-back: start held high, A=identity, B as in the reference run → done at 19 and 39; second run's c equals B.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the 4x4 systolic array feeder.
package systolic_pkg;

    localparam int N = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } feed_state_t;

    function automatic int mat_idx(input int r, input int c, input int w);
        return (r * N + c) * w;
    endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed edge lane: emits element k-LANE of its vector while feeding.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int LANE   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [2:0]                 k,
    input  logic [N*DATA_W-1:0]        elems,
    output logic signed [DATA_W-1:0]   q
);

    logic [DATA_W-1:0] sel;

    always_comb begin
        sel = '0;
        for (int e = 0; e < N; e++) begin
            if (en && int'(k) == LANE + e) begin
                sel = elems[e*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= sel;
        end
    end

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Latches A and B, clears the array, streams skewed operands, waits, pulses done.
module systolic_feeder_4x4
    import systolic_pkg::*;
#(
    parameter int DATA_W       = systolic_pkg::DATA_W,
    parameter int DRAIN_CYCLES = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [16*DATA_W-1:0]      a_mat,
    input  logic [16*DATA_W-1:0]      b_mat,
    output logic                      arr_clr,
    output logic signed [DATA_W-1:0]  a1,
    output logic signed [DATA_W-1:0]  a2,
    output logic signed [DATA_W-1:0]  a3,
    output logic signed [DATA_W-1:0]  a4,
    output logic signed [DATA_W-1:0]  b1,
    output logic signed [DATA_W-1:0]  b2,
    output logic signed [DATA_W-1:0]  b3,
    output logic signed [DATA_W-1:0]  b4,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    feed_state_t state, state_n;
    logic [2:0]    k;
    logic [CW-1:0] dcnt;

    logic [16*DATA_W-1:0] a_lat, b_lat;
    logic [N*DATA_W-1:0]  a_row [N];
    logic [N*DATA_W-1:0]  b_col [N];
    logic signed [DATA_W-1:0] a_q [N];
    logic signed [DATA_W-1:0] b_q [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = CLEAR;
            CLEAR:   state_n = FEED;
            FEED:    if (k == 3'd6) state_n = DRAIN;
            DRAIN:   if (dcnt == CW'(DRAIN_CYCLES - 1)) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k    <= '0;
            dcnt <= '0;
        end else begin
            k    <= (state == FEED) ? k + 3'd1 : 3'd0;
            dcnt <= (state == DRAIN) ? dcnt + CW'(1) : '0;
        end
    end

    // Matrices are kept across reset; only a new start re-arms them.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && start) begin
            a_lat <= a_mat;
            b_lat <= b_mat;
        end
    end

    // Outputs lag the state by one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            arr_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            arr_clr <= (state == CLEAR);
            busy    <= (state != IDLE);
            done    <= (state == DONE);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar e = 0; e < N; e++) begin : g_gather
            assign a_row[i][e*DATA_W +: DATA_W] =
                a_lat[mat_idx(i, e, DATA_W) +: DATA_W];
            assign b_col[i][e*DATA_W +: DATA_W] =
                b_lat[mat_idx(e, i, DATA_W) +: DATA_W];
        end

        systolic_skew_lane #(.DATA_W(DATA_W), .LANE(i)) u_a (
            .clk   (clk),
            .rst   (rst),
            .en    (state == FEED),
            .k     (k),
            .elems (a_row[i]),
            .q     (a_q[i])
        );

        systolic_skew_lane #(.DATA_W(DATA_W), .LANE(i)) u_b (
            .clk   (clk),
            .rst   (rst),
            .en    (state == FEED),
            .k     (k),
            .elems (b_col[i]),
            .q     (b_q[i])
        );
    end

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];
    assign b4 = b_q[3];

endmodule
